reg_bus_master: RTL

- Initiator for the team's simple register bus (wr_en/rd_en/addr/wdata/rdata/overflow), i.e. the other end of the counter-peripheral slave interface.
- Accepts queued read/write commands over a valid/ready stream and buffers them in a small FIFO.
- Issues them one at a time as single-cycle bus strobes, and returns read data (plus the slave's overflow flag) on a valid/ready response stream.
- Sits between a controller/CPU-side sequencer and the peripheral's register port.

---
 rtl/reg_bus_master.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/reg_bus_master.sv
// Register-bus initiator: buffers read/write commands in a small FIFO and
// replays them one at a time as single-cycle wr_en/rd_en strobes. Read data
// and the slave overflow flag come back on a valid/ready response stream.
module reg_bus_master #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_ovf,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              overflow,
  output logic              busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 1 + ADDR_W + DATA_W;
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);
  // Index of the last WAIT cycle; unused when RD_LATENCY is 0.
  localparam logic [1:0] WaitLast = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [EntW-1:0]     mem_q [FIFO_DEPTH];
  logic [EntW-1:0]     mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic [1:0]          wait_q, wait_d;

  logic                push;
  logic                pop;
  logic [EntW-1:0]     head;
  logic                head_write;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;

  // cmd_ready is a registered copy of "not full", so a full FIFO never accepts.
  assign push       = cmd_valid & cmd_ready_q;
  assign head       = mem_q[rd_ptr_q];
  assign head_write = head[EntW-1];
  assign head_addr  = head[DATA_W +: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  // FIFO storage, pointers and occupancy; also derives cmd_ready and busy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_write, cmd_addr, cmd_wdata};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    cmd_ready_d = (cnt_d != Full);
    busy_d      = (cnt_d != '0) || (state_d != StIdle);
  end

  // Bus sequencing FSM: pop in IDLE, one strobe cycle, optional read wait, response.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_ovf_d   = rsp_ovf_q;
    wait_d      = wait_q;
    unique case (state_q)
      StIdle: begin
        if (cnt_q != '0) begin
          pop    = 1'b1;
          addr_d = head_addr;
          if (head_write) begin
            wdata_d = head_wdata;
            wr_en_d = 1'b1;
            state_d = StWrite;
          end else begin
            rd_en_d = 1'b1;
            state_d = StRead;
          end
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      StRead: begin
        if (RD_LATENCY == 0) begin
          rsp_rdata_d = rdata;
          rsp_ovf_d   = overflow;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          wait_d  = 2'd0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          rsp_rdata_d = rdata;
          rsp_ovf_d   = overflow;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      StResp: begin
        // Nothing else is popped until the response is taken.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO payload storage; flushed logically by resetting the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_ovf_q   <= 1'b0;
      wait_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_ovf_q   <= rsp_ovf_d;
      wait_q      <= wait_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule
